// File: rtl/alu_nibble_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble_sequencer_if
// Description : Request/response and 4-bit ALU slice signals of the nibble
//               sequencer, grouped with slave (sequencer) and master views.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_carry_in;
    logic             req_carry_disable;
    logic [1:0]       req_cmd;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;

    logic             busy;

    logic [7:0]       alu_args;
    logic             alu_carry_in;
    logic             alu_carry_disable;
    logic [1:0]       alu_cmd;
    logic [3:0]       alu_res;
    logic             alu_carry_out;

    modport slave (
        input  req_valid, req_a, req_b, req_carry_in, req_carry_disable, req_cmd,
        input  rsp_ready,
        input  alu_res, alu_carry_out,
        output req_ready, rsp_valid, rsp_result, rsp_carry, busy,
        output alu_args, alu_carry_in, alu_carry_disable, alu_cmd
    );

    modport master (
        output req_valid, req_a, req_b, req_carry_in, req_carry_disable, req_cmd,
        output rsp_ready,
        output alu_res, alu_carry_out,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, busy,
        input  alu_args, alu_carry_in, alu_carry_disable, alu_cmd
    );
endinterface
`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble_sequencer
// Description : Drives a 4-bit ALU slice one nibble per cycle (LSB first),
//               chaining its carry, to form a WIDTH-bit serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_nibble_sequencer_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic             cdis_q,   cdis_d;
    logic [1:0]       cmd_q,    cmd_d;

    logic [IDX_W+1:0] w_bit_ofs;
    logic             w_accept;

    assign w_bit_ofs = {idx_q, 2'b00};
    assign w_accept  = (state_q == C_ST_IDLE) && bus.req_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= C_ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cdis_q   <= 1'b0;
            cmd_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cdis_q   <= cdis_d;
            cmd_q    <= cmd_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (bus.req_valid)          state_d = C_ST_RUN;
            C_ST_RUN:  if (idx_q == C_IDX_LAST)    state_d = C_ST_DONE;
            C_ST_DONE: if (bus.rsp_ready)          state_d = C_ST_IDLE;
            default:                               state_d = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, nibble index, carry chain and result assembly
    // ------------------------------------------------------------------
    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cdis_d   = cdis_q;
        cmd_d    = cmd_q;
        if (w_accept) begin
            a_d      = bus.req_a;
            b_d      = bus.req_b;
            cdis_d   = bus.req_carry_disable;
            cmd_d    = bus.req_cmd;
            carry_d  = bus.req_carry_in;
            idx_d    = '0;
            result_d = '0;
        end else if (state_q == C_ST_RUN) begin
            // The slice's carry_out is chained verbatim, even with carry_disable set.
            result_d[w_bit_ofs +: 4] = bus.alu_res;
            carry_d                  = bus.alu_carry_out;
            if (idx_q != C_IDX_LAST) begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, forced to 0 under reset
    // ------------------------------------------------------------------
    always_comb begin
        bus.req_ready         = 1'b0;
        bus.rsp_valid         = 1'b0;
        bus.rsp_result        = '0;
        bus.rsp_carry         = 1'b0;
        bus.busy              = 1'b0;
        bus.alu_args          = 8'h00;
        bus.alu_carry_in      = 1'b0;
        bus.alu_carry_disable = 1'b0;
        bus.alu_cmd           = 2'b00;
        if (!rst) begin
            case (state_q)
                C_ST_IDLE: begin
                    bus.req_ready = 1'b1;
                end
                C_ST_RUN: begin
                    bus.busy              = 1'b1;
                    bus.alu_args          = {a_q[w_bit_ofs +: 4], b_q[w_bit_ofs +: 4]};
                    bus.alu_carry_in      = carry_q;
                    bus.alu_carry_disable = cdis_q;
                    bus.alu_cmd           = cmd_q;
                end
                C_ST_DONE: begin
                    bus.busy       = 1'b1;
                    bus.rsp_valid  = 1'b1;
                    bus.rsp_result = result_q;
                    bus.rsp_carry  = carry_q;
                end
                default: begin
                    bus.req_ready = 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_nibble_sequencer
// Description : Self-checking bench for alu_nibble_sequencer with an adder
//               stub on the ALU side and a whole-word arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_nibble_sequencer;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Adder stub standing in for alu_4bit
    logic [4:0] stub_sum;
    always_comb begin
        stub_sum          = {1'b0, bus.alu_args[7:4]} + {1'b0, bus.alu_args[3:0]} + {4'b0000, bus.alu_carry_in};
        bus.alu_res       = stub_sum[3:0];
        bus.alu_carry_out = stub_sum[4];
    end

    // Reference model: the whole operation is a WIDTH-bit add with carry.
    function automatic logic [16:0] model_sum(input logic [15:0] a, input logic [15:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {16'h0000, cin};
    endfunction

    // Carry entering nibble k = carry out of the low 4*k bits of the sum.
    function automatic logic model_cin(input logic [15:0] a, input logic [15:0] b, input logic cin, input int k);
        logic [15:0] m;
        logic [16:0] s;
        m = 16'((32'd1 << (4 * k)) - 32'd1);
        s = {1'b0, a & m} + {1'b0, b & m} + {16'h0000, cin};
        return s[4 * k];
    endfunction

    function automatic logic [7:0] model_args(input logic [15:0] a, input logic [15:0] b, input int k);
        return {a[4 * k +: 4], b[4 * k +: 4]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic cdis, input logic [1:0] cmd);
        bus.req_a             = a;
        bus.req_b             = b;
        bus.req_carry_in      = cin;
        bus.req_carry_disable = cdis;
        bus.req_cmd           = cmd;
        bus.req_valid         = 1'b1;
        tick();
        bus.req_valid         = 1'b0;
    endtask

    task automatic test_reset();
        rst                   = 1'b1;
        bus.req_valid         = 1'b1;
        bus.req_a             = 16'($urandom);
        bus.req_b             = 16'($urandom);
        bus.req_carry_in      = 1'b1;
        bus.req_carry_disable = 1'b1;
        bus.req_cmd           = 2'b11;
        bus.rsp_ready         = 1'b0;
        repeat (3) begin
            tick();
            total++;
            if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.alu_args, bus.alu_carry_in,
                 bus.alu_carry_disable, bus.alu_cmd, bus.rsp_result, bus.rsp_carry} !== 32'h0) begin
                bad++;
                $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b args=%h ci=%b cd=%b cmd=%b res=%h c=%b want all 0",
                         bus.req_ready, bus.rsp_valid, bus.busy, bus.alu_args, bus.alu_carry_in,
                         bus.alu_carry_disable, bus.alu_cmd, bus.rsp_result, bus.rsp_carry);
            end
        end
        bus.req_valid = 1'b0;
        rst           = 1'b0;
        #1;
        total++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: req_ready=%b busy=%b want 1 0", bus.req_ready, bus.busy);
        end
        tick();
        total++;
        if ({bus.req_ready, bus.busy, bus.alu_args} !== {2'b10, 8'h00}) begin
            bad++;
            $display("FAIL reset_no_start: req_ready=%b busy=%b args=%h want 1 0 00", bus.req_ready, bus.busy, bus.alu_args);
        end
    endtask

    task automatic test_carry_chain();
        logic [3:0] exp_ci;
        exp_ci = 4'b1110;  // nibble 0 gets cin=0, then 1,1,1
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL chain_ready: got %b want 1", bus.req_ready);
        end
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 2'b10);
        for (int k = 0; k < NIB; k++) begin
            total++;
            if ({bus.busy, bus.rsp_valid, bus.alu_carry_in, bus.alu_cmd, bus.rsp_result} !== {2'b10, exp_ci[k], 2'b10, 16'h0000}) begin
                bad++;
                $display("FAIL chain_run%0d: busy=%b vld=%b ci=%b cmd=%b res=%h want 1 0 %b 10 0000",
                         k, bus.busy, bus.rsp_valid, bus.alu_carry_in, bus.alu_cmd, bus.rsp_result, exp_ci[k]);
            end
            tick();
        end
        total++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, 16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL chain_result: vld=%b res=%h c=%b want 1 0000 1", bus.rsp_valid, bus.rsp_result, bus.rsp_carry);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.req_ready, bus.busy, bus.rsp_result} !== {3'b010, 16'h0000}) begin
            bad++;
            $display("FAIL chain_release: vld=%b rdy=%b busy=%b res=%h want 0 1 0 0000",
                     bus.rsp_valid, bus.req_ready, bus.busy, bus.rsp_result);
        end
    endtask

    task automatic test_nibble_order();
        logic [7:0] exp_args [NIB];
        exp_args = '{8'h4D, 8'h3C, 8'h2F, 8'h10};
        issue(16'h1234, 16'h0FCD, 1'b1, 1'b0, 2'b01);
        for (int k = 0; k < NIB; k++) begin
            total++;
            if (bus.alu_args !== exp_args[k]) begin
                bad++;
                $display("FAIL order_args%0d: got %h want %h", k, bus.alu_args, exp_args[k]);
            end
            tick();
        end
        total++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, 16'h2202, 1'b0}) begin
            bad++;
            $display("FAIL order_result: vld=%b res=%h c=%b want 1 2202 0", bus.rsp_valid, bus.rsp_result, bus.rsp_carry);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b, pa, pb;
        logic        cin, pcin;
        logic [16:0] exp;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        pa = 16'($urandom); pb = 16'($urandom); pcin = 1'($urandom);
        exp = model_sum(a, b, cin);
        bus.rsp_ready = 1'b0;
        issue(a, b, cin, 1'b0, 2'b00);
        repeat (NIB) tick();
        bus.req_a = pa; bus.req_b = pb; bus.req_carry_in = pcin;
        bus.req_carry_disable = 1'b0; bus.req_cmd = 2'b00;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_carry} !== {2'b10, exp[15:0], exp[16]}) begin
                bad++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b res=%h c=%b want 1 0 %h %b",
                         i, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_carry, exp[15:0], exp[16]);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.req_ready, bus.busy} !== 3'b010) begin
            bad++;
            $display("FAIL bp_idle: vld=%b rdy=%b busy=%b want 0 1 0", bus.rsp_valid, bus.req_ready, bus.busy);
        end
        tick();
        bus.req_valid = 1'b0;
        total++;
        if ({bus.busy, bus.alu_args, bus.alu_carry_in} !== {1'b1, model_args(pa, pb, 0), pcin}) begin
            bad++;
            $display("FAIL bp_pending_accept: busy=%b args=%h ci=%b want 1 %h %b",
                     bus.busy, bus.alu_args, bus.alu_carry_in, model_args(pa, pb, 0), pcin);
        end
        repeat (NIB) tick();
        exp = model_sum(pa, pb, pcin);
        total++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, exp[15:0], exp[16]}) begin
            bad++;
            $display("FAIL bp_pending_result: vld=%b res=%h c=%b want 1 %h %b",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_carry, exp[15:0], exp[16]);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] a, b;
        logic        cin;
        logic [16:0] exp;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        issue(a, b, cin, 1'b1, 2'b11);
        tick();
        tick();
        total++;
        if (bus.alu_args !== model_args(a, b, 2)) begin
            bad++;
            $display("FAIL rstmid_idx2: args=%h want %h", bus.alu_args, model_args(a, b, 2));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.req_ready, bus.rsp_valid} !== 3'b010) begin
            bad++;
            $display("FAIL rstmid_idle: busy=%b rdy=%b vld=%b want 0 1 0", bus.busy, bus.req_ready, bus.rsp_valid);
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({bus.rsp_valid, bus.busy, bus.rsp_result} !== {2'b00, 16'h0000}) begin
                bad++;
                $display("FAIL rstmid_quiet%0d: vld=%b busy=%b res=%h want 0 0 0000", i, bus.rsp_valid, bus.busy, bus.rsp_result);
            end
        end
        bus.rsp_ready = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'b0;
        exp = model_sum(a, b, cin);
        issue(a, b, cin, 1'b0, 2'b00);
        repeat (NIB) tick();
        total++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, exp[15:0], exp[16]}) begin
            bad++;
            $display("FAIL rstmid_next: vld=%b res=%h c=%b want 1 %h %b",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_carry, exp[15:0], exp[16]);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_isolation();
        logic [15:0] a, b;
        logic        cin, cdis;
        logic [1:0]  cmd;
        logic [16:0] exp;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        cdis = 1'b1; cmd = 2'($urandom);
        exp = model_sum(a, b, cin);
        issue(a, b, cin, cdis, cmd);
        for (int k = 0; k < NIB; k++) begin
            bus.req_a = 16'($urandom); bus.req_b = 16'($urandom);
            bus.req_carry_in = 1'($urandom); bus.req_carry_disable = 1'($urandom);
            bus.req_cmd = 2'($urandom); bus.req_valid = 1'($urandom);
            #1;
            total++;
            if ({bus.alu_args, bus.alu_carry_in, bus.alu_carry_disable, bus.alu_cmd} !==
                {model_args(a, b, k), model_cin(a, b, cin, k), cdis, cmd}) begin
                bad++;
                $display("FAIL iso_run%0d: args=%h ci=%b cd=%b cmd=%b want %h %b %b %b", k, bus.alu_args,
                         bus.alu_carry_in, bus.alu_carry_disable, bus.alu_cmd,
                         model_args(a, b, k), model_cin(a, b, cin, k), cdis, cmd);
            end
            tick();
        end
        bus.req_valid = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, exp[15:0], exp[16]}) begin
            bad++;
            $display("FAIL iso_result: vld=%b res=%h c=%b want 1 %h %b",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_carry, exp[15:0], exp[16]);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        logic        cin, cdis, pre_ready;
        logic [1:0]  cmd;
        logic [16:0] exp;
        int          wait_cyc;
        for (int n = 0; n < 20; n++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            cdis = 1'($urandom); cmd = 2'($urandom);
            pre_ready = 1'($urandom);
            wait_cyc  = $urandom_range(0, 3);
            exp = model_sum(a, b, cin);
            total++;
            if (bus.req_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready%0d: got %b want 1", n, bus.req_ready);
            end
            issue(a, b, cin, cdis, cmd);
            bus.rsp_ready = pre_ready;
            for (int k = 0; k < NIB; k++) begin
                total++;
                if ({bus.rsp_valid, bus.alu_args, bus.alu_carry_in, bus.alu_carry_disable, bus.alu_cmd} !==
                    {1'b0, model_args(a, b, k), model_cin(a, b, cin, k), cdis, cmd}) begin
                    bad++;
                    $display("FAIL b2b_run%0d_%0d: vld=%b args=%h ci=%b cd=%b cmd=%b want 0 %h %b %b %b",
                             n, k, bus.rsp_valid, bus.alu_args, bus.alu_carry_in, bus.alu_carry_disable,
                             bus.alu_cmd, model_args(a, b, k), model_cin(a, b, cin, k), cdis, cmd);
                end
                tick();
            end
            total++;
            if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, exp[15:0], exp[16]}) begin
                bad++;
                $display("FAIL b2b_result%0d: vld=%b res=%h c=%b want 1 %h %b",
                         n, bus.rsp_valid, bus.rsp_result, bus.rsp_carry, exp[15:0], exp[16]);
            end
            if (!pre_ready) begin
                for (int w = 0; w < wait_cyc; w++) begin
                    tick();
                    total++;
                    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry} !== {1'b1, exp[15:0], exp[16]}) begin
                        bad++;
                        $display("FAIL b2b_stall%0d: vld=%b res=%h c=%b want 1 %h %b",
                                 n, bus.rsp_valid, bus.rsp_result, bus.rsp_carry, exp[15:0], exp[16]);
                    end
                end
                bus.rsp_ready = 1'b1;
            end
            tick();
            bus.rsp_ready = 1'b0;
            total++;
            if ({bus.rsp_valid, bus.busy, bus.rsp_result, bus.rsp_carry} !== {2'b00, 16'h0000, 1'b0}) begin
                bad++;
                $display("FAIL b2b_release%0d: vld=%b busy=%b res=%h c=%b want 0 0 0000 0",
                         n, bus.rsp_valid, bus.busy, bus.rsp_result, bus.rsp_carry);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_carry_chain();
        test_nibble_order();
        test_backpressure();
        test_reset_mid();
        test_isolation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
